serial_operand_feeder: RTL and testbench
========================================

SERIAL_OPERAND_FEEDER -- requirements
Module: serial_operand_feeder

Interface
REQ-001 SHALL have parameter N, default 2: number of input/weight lanes.
REQ-002 SHALL have parameter width, default 8: bits per operand, two's complement.
REQ-003 SHALL have parameter gap, default 2*width: minimum idle cycles between the last bit of one frame and the next start.
REQ-004 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1: reset, synchronous and active-high.
REQ-006 SHALL have port load_valid  input  1: a parallel frame is offered.
REQ-007 SHALL have port load_ready  output  1: the frame is accepted on any cycle where load_valid and load_ready are both high.
REQ-008 SHALL have port load_inp  input  N*width: lane i occupies bits [i*width+width-1 : i*width].
REQ-009 SHALL have port load_w  input  N*width: weights, packed like load_inp.
REQ-010 SHALL have port start  output  1: one-cycle pulse marking bit 0 of a frame.
REQ-011 SHALL have port inp  output  N: bit-serial input streams, LSB first.
REQ-012 SHALL have port w  output  N: bit-serial weight streams, LSB first.
REQ-013 SHALL have port busy  output  1: high while in SHIFT or GAP.

Function
REQ-014 SHALL contain a shift register (inp and w, N*width bits each) and a one-frame holding buffer with a valid flag.
REQ-015 SHALL drive load_ready = ~hold_valid (combinational from registered state).
- An accepted frame goes into the holding buffer.
REQ-016 SHALL implement FSM states IDLE, SHIFT and GAP.
- IDLE -> SHIFT when hold_valid = 1.
- SHIFT -> GAP after width bit-cycles, or SHIFT -> IDLE when gap = 0 and hold_valid = 0.
- GAP -> IDLE after gap cycles.
REQ-017 SHALL move the holding buffer into the shift register on entering SHIFT, which clears hold_valid in the same cycle.
- A load accepted in that same cycle sets hold_valid again; set wins.
REQ-018 SHALL assert start in exactly the cycle in which bit 0 of every lane appears on inp and w.
- Bit k appears k cycles later, for k = 0..width-1.
REQ-019 SHALL drive inp and w to 0 in every cycle outside the width bit-cycles of a frame.
REQ-020 SHALL, when gap = 0 and hold_valid = 1 at the last bit, start the next frame on the following cycle.
- This gives back-to-back frames with no idle cycle.
REQ-021 SHALL give a load-to-start latency of 2 cycles from an IDLE state with an empty buffer.
- Acceptance edge, then transfer edge; start is a registered output.
REQ-022 SHALL use a bit counter of log2(width)+1 bits and a gap counter of log2(gap)+1 bits.
- Counters never wrap; their terminal-count compares are exact.
REQ-023 SHALL keep start, inp and w as registered outputs.
REQ-024 SHALL ignore load_valid while load_ready = 0; inputs are not sampled in that case.

Reset
REQ-025 SHALL, with rst high at an edge, force the following regardless of FSM state (including mid-frame):
- state IDLE, hold_valid 0, counters 0, start 0, inp 0, w 0, busy 0.
REQ-026 SHALL drop a frame interrupted by reset without emitting any further bits.
REQ-027 SHALL drive load_ready = 1 on the first cycle after rst deasserts.

Structure
REQ-028 SHALL take the log2 constant function and the FSM state encoding (IDLE=0, SHIFT=1, GAP=2, 2 bits) from a shared package, neuron_pkg.
REQ-029 SHALL contain no sub-module.
- Lanes are a generate loop over a single shift/hold slice.
- Counters and the FSM stay in the top level.

Verification
REQ-030 Single frame, N=2, width=8, load_inp={8'h05,8'h03}, load_w={8'hFF,8'h02}:
- start occurs 2 cycles after the load.
- inp[0] shows 1,1,0,0,0,0,0,0.
- w[1] shows 1 for 8 cycles; then all outputs are 0.
REQ-031 Back-pressure: present 3 frames on consecutive cycles:
- the second is accepted only after the first enters SHIFT;
- load_ready stays low for the third until the second transfers;
- all 3 streams appear in order with start spacing 8+gap = 24 cycles.
REQ-032 gap=0, two queued frames:
- start pulses are exactly 8 cycles apart;
- there is no zero cycle between the last bit of frame 1 and bit 0 of frame 2.
REQ-033 Reset at bit 4 of a frame:
- next cycle inp = w = 0, start = 0, busy = 0, load_ready = 1;
- a new frame loaded afterwards produces start 2 cycles later.
REQ-034 Load accepted on the same edge the buffer transfers to SHIFT:
- hold_valid = 1 afterwards;
- the second frame starts 8+gap cycles after the first.
REQ-035 Negative operand, width=8, value 8'h80:
- lane emits 0,0,0,0,0,0,0,1 LSB first, then 0.

Source files
------------

// File: rtl/neuron_pkg.sv
// Shared definitions for the neuron datapath: FSM state encoding and a
// compile-time log2 used to size counters.
package neuron_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Ceiling log2; log2(0) and log2(1) both give 0.
  function automatic int log2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/serial_operand_feeder.sv
// Accepts parallel input/weight frames and streams them out bit-serially,
// LSB first, with a one-frame holding buffer and a minimum inter-frame gap.
//
// state | meaning
// IDLE  | no frame on the serial outputs; waits for a buffered frame
// SHIFT | emitting the width bits of the current frame
// GAP   | enforced idle cycles after the last bit of a frame
module serial_operand_feeder
  import neuron_pkg::*;
#(
  parameter int N     = 2,
  parameter int width = 8,
  parameter int gap   = 2 * width
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_valid,
  output logic                 load_ready,
  input  logic [N*width-1:0]   load_inp,
  input  logic [N*width-1:0]   load_w,
  output logic                 start,
  output logic [N-1:0]         inp,
  output logic [N-1:0]         w,
  output logic                 busy
);

  localparam int BW = log2(width) + 1;
  localparam int GW = log2(gap) + 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(width - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((gap > 0) ? gap - 1 : 0);

  state_t        state;
  logic          hold_valid;
  logic [BW-1:0] bit_cnt;
  logic [GW-1:0] gap_cnt;
  logic          accept;
  logic          last_bit;
  logic          gap_done;
  logic          transfer;
  logic          shift_en;

  assign load_ready = ~hold_valid;
  assign accept     = load_valid & ~hold_valid;
  assign last_bit   = (state == SHIFT) && (bit_cnt == '0);
  assign gap_done   = (state == GAP) && (gap_cnt == '0);
  // A buffered frame launches from IDLE, at the end of the gap, or straight
  // after the last bit when there is no gap, so spacing is exactly width+gap.
  assign transfer   = hold_valid && ((state == IDLE) || gap_done || (last_bit && (gap == 0)));
  assign shift_en   = (state == SHIFT) && (bit_cnt != '0);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      hold_valid <= 1'b0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      start      <= 1'b0;
    end else begin
      start      <= transfer;
      hold_valid <= accept | (hold_valid & ~transfer);
      if (transfer) begin
        state   <= SHIFT;
        bit_cnt <= BIT_LAST;
      end else begin
        case (state)
          SHIFT: begin
            if (bit_cnt != '0) begin
              bit_cnt <= bit_cnt - 1'b1;
            end else if (gap == 0) begin
              state <= IDLE;
            end else begin
              state   <= GAP;
              gap_cnt <= GAP_LAST;
            end
          end
          GAP: begin
            if (gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
            else               state   <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [width-1:0] hold_inp;
    logic [width-1:0] hold_w;
    logic [width-1:0] sreg_inp;
    logic [width-1:0] sreg_w;
    logic             inp_q;
    logic             w_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        hold_inp <= '0;
        hold_w   <= '0;
        sreg_inp <= '0;
        sreg_w   <= '0;
        inp_q    <= 1'b0;
        w_q      <= 1'b0;
      end else begin
        if (accept) begin
          hold_inp <= load_inp[i*width +: width];
          hold_w   <= load_w[i*width +: width];
        end
        // Bit 0 goes straight to the output register on transfer; the shift
        // register only holds the bits still to come.
        if (transfer) begin
          inp_q    <= hold_inp[0];
          w_q      <= hold_w[0];
          sreg_inp <= hold_inp >> 1;
          sreg_w   <= hold_w >> 1;
        end else if (shift_en) begin
          inp_q    <= sreg_inp[0];
          w_q      <= sreg_w[0];
          sreg_inp <= sreg_inp >> 1;
          sreg_w   <= sreg_w >> 1;
        end else begin
          inp_q <= 1'b0;
          w_q   <= 1'b0;
        end
      end
    end

    assign inp[i] = inp_q;
    assign w[i]   = w_q;
  end

endmodule

// File: tb/tb_serial_operand_feeder.sv
// Directed bench: one feeder with the default gap (16) and one with gap=0,
// sharing stimulus; per-cycle outputs are logged and then checked.
module tb_serial_operand_feeder;

  typedef struct packed {
    logic [15:0] inp;
    logic [15:0] w;
  } frame_t;

  logic        clk;
  logic        rst;
  logic        sel;
  logic        load_valid;
  logic [15:0] load_inp;
  logic [15:0] load_w;

  logic       a_ready, a_start, a_busy;
  logic [1:0] a_inp, a_w;
  logic       b_ready, b_start, b_busy;
  logic [1:0] b_inp, b_w;

  logic       mon_ready, mon_start, mon_busy;
  logic [1:0] mon_inp, mon_w;

  int n_vec;
  int n_miss;

  frame_t fq[$];
  logic       log_start [128];
  logic       log_ready [128];
  logic       log_busy  [128];
  logic       log_acc   [128];
  logic [1:0] log_inp   [128];
  logic [1:0] log_w     [128];
  int         run_len;

  serial_operand_feeder #(.N(2), .width(8)) dut_a (
    .clk(clk), .rst(rst), .load_valid(load_valid & ~sel), .load_ready(a_ready),
    .load_inp(load_inp), .load_w(load_w), .start(a_start), .inp(a_inp),
    .w(a_w), .busy(a_busy)
  );

  serial_operand_feeder #(.N(2), .width(8), .gap(0)) dut_b (
    .clk(clk), .rst(rst), .load_valid(load_valid & sel), .load_ready(b_ready),
    .load_inp(load_inp), .load_w(load_w), .start(b_start), .inp(b_inp),
    .w(b_w), .busy(b_busy)
  );

  assign mon_ready = sel ? b_ready : a_ready;
  assign mon_start = sel ? b_start : a_start;
  assign mon_busy  = sel ? b_busy  : a_busy;
  assign mon_inp   = sel ? b_inp   : a_inp;
  assign mon_w     = sel ? b_w     : a_w;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    load_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Offers queued frames back to back, logging outputs of each cycle.
  task automatic run(input int ncyc);
    logic acc;
    run_len = ncyc;
    for (int c = 0; c < ncyc; c++) begin
      if (fq.size() > 0) begin
        load_valid = 1'b1;
        load_inp   = fq[0].inp;
        load_w     = fq[0].w;
      end else begin
        load_valid = 1'b0;
      end
      #1;
      log_start[c] = mon_start;
      log_ready[c] = mon_ready;
      log_busy[c]  = mon_busy;
      log_inp[c]   = mon_inp;
      log_w[c]     = mon_w;
      acc          = load_valid & mon_ready;
      log_acc[c]   = acc;
      @(posedge clk);
      #1;
      if (acc) void'(fq.pop_front());
    end
    load_valid = 1'b0;
  endtask

  task automatic check_frame(input string tag, input int c0, input frame_t fr);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("%s_start_b%0d", tag, k), 32'(log_start[c0+k]), 32'(k == 0));
      chk($sformatf("%s_inp_b%0d", tag, k), 32'(log_inp[c0+k]), 32'({fr.inp[8+k], fr.inp[k]}));
      chk($sformatf("%s_w_b%0d", tag, k), 32'(log_w[c0+k]), 32'({fr.w[8+k], fr.w[k]}));
    end
  endtask

  task automatic check_starts(input string tag, input int exp[$]);
    int got[$];
    for (int c = 0; c < run_len; c++) if (log_start[c]) got.push_back(c);
    chk({tag, "_count"}, 32'(got.size()), 32'(exp.size()));
    for (int j = 0; j < exp.size() && j < got.size(); j++)
      chk($sformatf("%s_at%0d", tag, j), 32'(got[j]), 32'(exp[j]));
  endtask

  task automatic check_quiet(input string tag, input int c_from, input int c_to);
    int nz;
    nz = 0;
    for (int c = c_from; c <= c_to; c++) if (log_inp[c] != 2'b00 || log_w[c] != 2'b00) nz++;
    chk(tag, 32'(nz), 32'd0);
  endtask

  frame_t fa, fb, fc, fd, fe, fn;

  initial begin
    n_vec      = 0;
    n_miss     = 0;
    sel        = 1'b0;
    rst        = 1'b1;
    load_valid = 1'b0;
    load_inp   = '0;
    load_w     = '0;

    fa = '{inp: {8'h05, 8'h03}, w: {8'hFF, 8'h02}};
    fb = '{inp: {8'h81, 8'h5A}, w: {8'h3C, 8'hC3}};
    fc = '{inp: {8'h7E, 8'hA5}, w: {8'h01, 8'h80}};
    fd = '{inp: {8'h00, 8'hF0}, w: {8'h1F, 8'h00}};
    fe = '{inp: {8'h81, 8'h81}, w: {8'hC1, 8'h83}};
    fn = '{inp: {8'h00, 8'h80}, w: {8'h80, 8'h00}};

    // Reset state
    do_reset();
    chk("rst_ready", 32'(mon_ready), 32'd1);
    chk("rst_busy",  32'(mon_busy),  32'd0);
    chk("rst_start", 32'(mon_start), 32'd0);
    chk("rst_inp",   32'(mon_inp),   32'd0);
    chk("rst_w",     32'(mon_w),     32'd0);

    // Single frame: start 2 cycles after load, then 16 gap cycles
    fq = '{fa};
    run(30);
    check_starts("single_start", '{2});
    check_frame("single", 2, fa);
    chk("single_inp0_b1", 32'(log_inp[3][0]), 32'd1);
    chk("single_w1_b7",   32'(log_w[9][1]),   32'd1);
    chk("single_busy_hold", 32'(log_busy[1]),  32'd0);
    chk("single_busy_gap",  32'(log_busy[25]), 32'd1);
    chk("single_busy_idle", 32'(log_busy[26]), 32'd0);
    check_quiet("single_quiet_pre",  0, 1);
    check_quiet("single_quiet_post", 10, 29);

    // Back-pressure: three frames offered on consecutive cycles
    do_reset();
    fq = '{fa, fb, fc};
    run(80);
    chk("bp_acc0",   32'(log_acc[0]),   32'd1);
    chk("bp_ready1", 32'(log_ready[1]), 32'd0);
    chk("bp_acc2",   32'(log_acc[2]),   32'd1);
    chk("bp_ready3", 32'(log_ready[3]), 32'd0);
    chk("bp_ready25", 32'(log_ready[25]), 32'd0);
    chk("bp_acc26",  32'(log_acc[26]),  32'd1);
    check_starts("bp_start", '{2, 26, 50});
    check_frame("bp_f1", 2, fa);
    check_frame("bp_f2", 26, fb);
    check_frame("bp_f3", 50, fc);
    check_quiet("bp_quiet_gap", 10, 25);
    check_quiet("bp_quiet_end", 58, 79);

    // Load taken right after the transfer edge: buffer refills, spacing 24
    do_reset();
    fq = '{fc, fe};
    run(40);
    chk("refill_hold", 32'(log_ready[3]), 32'd0);
    check_starts("refill_start", '{2, 26});
    check_frame("refill_f2", 26, fe);

    // gap=0: back-to-back frames with no zero cycle between them
    sel = 1'b1;
    do_reset();
    fq = '{fe, fb};
    run(24);
    check_starts("gap0_start", '{2, 10});
    check_frame("gap0_f1", 2, fe);
    check_frame("gap0_f2", 10, fb);
    chk("gap0_busy_last", 32'(log_busy[17]), 32'd1);
    chk("gap0_busy_idle", 32'(log_busy[18]), 32'd0);
    check_quiet("gap0_quiet", 18, 23);
    sel = 1'b0;

    // Reset at bit 4 of a frame
    do_reset();
    fq = '{fd};
    run(6);
    chk("mid_bit4_inp", 32'(mon_inp), 32'h1);
    chk("mid_bit4_w",   32'(mon_w),   32'h2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mid_rst_inp",   32'(mon_inp),   32'd0);
    chk("mid_rst_w",     32'(mon_w),     32'd0);
    chk("mid_rst_start", 32'(mon_start), 32'd0);
    chk("mid_rst_busy",  32'(mon_busy),  32'd0);
    chk("mid_rst_ready", 32'(mon_ready), 32'd1);
    fq = '{fb};
    run(14);
    check_starts("mid_restart", '{2});
    check_quiet("mid_no_stale", 0, 1);
    check_frame("mid_new", 2, fb);

    // Most negative operand 8'h80
    do_reset();
    fq = '{fn};
    run(14);
    check_starts("neg_start", '{2});
    check_frame("neg", 2, fn);
    chk("neg_inp0_b7", 32'(log_inp[9][0]), 32'd1);
    chk("neg_inp0_after", 32'(log_inp[10][0]), 32'd0);
    chk("neg_w1_after",   32'(log_w[10][1]),   32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
